eight_point_ifft: RTL and testbench

Sequential 8-point radix-2 inverse FFT, the return path paired with `eight_point_fft`. It accepts one frequency-domain frame in sign-magnitude format. It computes the frame with a single time-shared butterfly over 12 cycles and presents the time-domain frame in sign-magnitude on registered outputs with a `ready` flag. It sits between the spectral processing stage and the sample output path.

---
 rtl/fft_pkg.sv | 33 +++
 rtl/ifft_bfly.sv | 46 ++++
 rtl/eight_point_ifft.sv | 158 +++++++++++++++
 tb/tb_eight_point_ifft.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared widths, twiddle constant, FSM encoding and helpers for the 8-point FFT/IFFT datapath.
package fft_pkg;

  localparam int DW    = 16;
  localparam int IW    = DW + 3;
  localparam int C_Q15 = 23170;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Twiddle factors used by the inverse transform (positive exponent).
  typedef enum logic [1:0] {
    TW_ONE = 2'd0,
    TW_J   = 2'd1,
    TW_C   = 2'd2,
    TW_NC  = 2'd3
  } tw_sel_e;

  function automatic logic [2:0] rev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  // Sign-magnitude to two's complement; negative zero folds to zero.
  function automatic logic signed [IW-1:0] sm_to_tc(input logic [DW-1:0] sm);
    logic signed [IW-1:0] mag;
    mag = {{(IW-DW+1){1'b0}}, sm[DW-2:0]};
    return sm[DW-1] ? -mag : mag;
  endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 complex butterfly: returns a+W*b and a-W*b at internal width.
module ifft_bfly
  import fft_pkg::*;
(
  input  logic signed [IW-1:0] a_re,
  input  logic signed [IW-1:0] a_im,
  input  logic signed [IW-1:0] b_re,
  input  logic signed [IW-1:0] b_im,
  input  tw_sel_e              tw_sel,
  output logic signed [IW-1:0] sum_re,
  output logic signed [IW-1:0] sum_im,
  output logic signed [IW-1:0] dif_re,
  output logic signed [IW-1:0] dif_im
);

  localparam logic signed [IW+16:0] C_W  = (IW+17)'(C_Q15);
  localparam logic signed [IW+16:0] HALF = (IW+17)'(1 << 14);

  // Q15 multiply by C with round-half-up.
  function automatic logic signed [IW-1:0] mul_c(input logic signed [IW-1:0] x);
    logic signed [IW+16:0] prod;
    prod = (IW+17)'(x) * C_W + HALF;
    return prod[IW+14:15];
  endfunction

  logic signed [IW-1:0] cr, ci, wb_re, wb_im;

  always_comb begin
    cr    = mul_c(b_re);
    ci    = mul_c(b_im);
    wb_re = b_re;
    wb_im = b_im;
    case (tw_sel)
      TW_J:    begin wb_re = -b_im;    wb_im = b_re;    end
      TW_C:    begin wb_re = cr - ci;  wb_im = cr + ci; end
      TW_NC:   begin wb_re = -cr - ci; wb_im = cr - ci; end
      default: ;
    endcase
  end

  assign sum_re = a_re + wb_re;
  assign sum_im = a_im + wb_im;
  assign dif_re = a_re - wb_re;
  assign dif_im = a_im - wb_im;

endmodule

// File: rtl/eight_point_ifft.sv
// Sequential 8-point inverse FFT, one time-shared butterfly over 12 cycles.
// Define IFFT_SCALE_EN for a 1/8-scaled result; default output is the unscaled sum.
module eight_point_ifft
  import fft_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          write,
  input  logic          start,
  input  logic [DW-1:0] in0_real, in1_real, in2_real, in3_real,
  input  logic [DW-1:0] in4_real, in5_real, in6_real, in7_real,
  input  logic [DW-1:0] in0_imag, in1_imag, in2_imag, in3_imag,
  input  logic [DW-1:0] in4_imag, in5_imag, in6_imag, in7_imag,
  output logic [DW-1:0] out0_real, out1_real, out2_real, out3_real,
  output logic [DW-1:0] out4_real, out5_real, out6_real, out7_real,
  output logic [DW-1:0] out0_imag, out1_imag, out2_imag, out3_imag,
  output logic [DW-1:0] out4_imag, out5_imag, out6_imag, out7_imag,
  output logic          busy,
  output logic          ready
);

  localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (DW-1)) - 1);
  localparam logic signed [IW-1:0] RND8    = IW'(4);

  function automatic logic [DW-1:0] to_sm(input logic signed [IW-1:0] x);
    logic signed [IW-1:0] v, mag;
`ifdef IFFT_SCALE_EN
    v = (x + RND8) >>> 3;
`else
    v = x;
`endif
    if (v > SAT_MAX)       v = SAT_MAX;
    else if (v < -SAT_MAX) v = -SAT_MAX;
    mag = v[IW-1] ? -v : v;
    return {v[IW-1], mag[DW-2:0]};
  endfunction

  logic [DW-1:0] in_re [8];
  logic [DW-1:0] in_im [8];
  assign in_re = '{in0_real, in1_real, in2_real, in3_real, in4_real, in5_real, in6_real, in7_real};
  assign in_im = '{in0_imag, in1_imag, in2_imag, in3_imag, in4_imag, in5_imag, in6_imag, in7_imag};

  state_e               state_reg;
  logic [1:0]           s_reg, b_reg;
  logic                 ready_reg, busy_reg;
  logic signed [IW-1:0] work_re_reg [8];
  logic signed [IW-1:0] work_im_reg [8];
  logic [DW-1:0]        out_re_reg [8];
  logic [DW-1:0]        out_im_reg [8];

  logic [2:0]           p_idx, q_idx;
  tw_sel_e              tw_sel;
  logic signed [IW-1:0] sum_re, sum_im, dif_re, dif_im;

  // Butterfly addressing: p = (b>>s)*2h + (b mod h), q = p + h.
  always_comb begin
    p_idx  = '0;
    q_idx  = '0;
    tw_sel = TW_ONE;
    case (s_reg)
      2'd0: begin
        p_idx = {b_reg, 1'b0};
        q_idx = {b_reg, 1'b1};
      end
      2'd1: begin
        p_idx  = {b_reg[1], 1'b0, b_reg[0]};
        q_idx  = {b_reg[1], 1'b1, b_reg[0]};
        tw_sel = b_reg[0] ? TW_J : TW_ONE;
      end
      default: begin
        p_idx = {1'b0, b_reg};
        q_idx = {1'b1, b_reg};
        case (b_reg)
          2'd1:    tw_sel = TW_C;
          2'd2:    tw_sel = TW_J;
          2'd3:    tw_sel = TW_NC;
          default: tw_sel = TW_ONE;
        endcase
      end
    endcase
  end

  ifft_bfly u_bfly (
    .a_re   (work_re_reg[p_idx]),
    .a_im   (work_im_reg[p_idx]),
    .b_re   (work_re_reg[q_idx]),
    .b_im   (work_im_reg[q_idx]),
    .tw_sel (tw_sel),
    .sum_re (sum_re),
    .sum_im (sum_im),
    .dif_re (dif_re),
    .dif_im (dif_im)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      b_reg     <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        work_re_reg[i] <= '0;
        work_im_reg[i] <= '0;
        out_re_reg[i]  <= '0;
        out_im_reg[i]  <= '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Bins land in bit-reversed slots so the in-place passes finish in natural order.
          if (write) begin
            for (int i = 0; i < 8; i++) begin
              work_re_reg[i] <= sm_to_tc(in_re[rev3(3'(i))]);
              work_im_reg[i] <= sm_to_tc(in_im[rev3(3'(i))]);
            end
          end
          if (write || start) ready_reg <= 1'b0;
          if (start) begin
            state_reg <= ST_BUSY;
            busy_reg  <= 1'b1;
            s_reg     <= '0;
            b_reg     <= '0;
          end
        end
        ST_BUSY: begin
          work_re_reg[p_idx] <= sum_re;
          work_im_reg[p_idx] <= sum_im;
          work_re_reg[q_idx] <= dif_re;
          work_im_reg[q_idx] <= dif_im;
          b_reg <= b_reg + 2'd1;
          if (b_reg == 2'd3) begin
            s_reg <= s_reg + 2'd1;
            if (s_reg == 2'd2) state_reg <= ST_OUT;
          end
        end
        ST_OUT: begin
          for (int i = 0; i < 8; i++) begin
            out_re_reg[i] <= to_sm(work_re_reg[i]);
            out_im_reg[i] <= to_sm(work_im_reg[i]);
          end
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign {out0_real, out1_real, out2_real, out3_real} = {out_re_reg[0], out_re_reg[1], out_re_reg[2], out_re_reg[3]};
  assign {out4_real, out5_real, out6_real, out7_real} = {out_re_reg[4], out_re_reg[5], out_re_reg[6], out_re_reg[7]};
  assign {out0_imag, out1_imag, out2_imag, out3_imag} = {out_im_reg[0], out_im_reg[1], out_im_reg[2], out_im_reg[3]};
  assign {out4_imag, out5_imag, out6_imag, out7_imag} = {out_im_reg[4], out_im_reg[5], out_im_reg[6], out_im_reg[7]};
  assign busy  = busy_reg;
  assign ready = ready_reg;

endmodule

// File: tb/tb_eight_point_ifft.sv
// Self-checking bench for eight_point_ifft: floating-point IDFT reference feeding a result scoreboard.
module tb_eight_point_ifft;

  localparam real PI = 3.14159265358979;

  logic        CLK, RST_N, write, start;
  logic [15:0] x_re [8];
  logic [15:0] x_im [8];
  logic [15:0] y_re [8];
  logic [15:0] y_im [8];
  logic        busy, ready;

  int    checks = 0;
  int    errors = 0;
  int    exp_q[$];
  int    tol_q[$];
  string name_q[$];
  int    last_exp_re0, last_tol;

  eight_point_ifft dut (
    .CLK(CLK), .RST_N(RST_N), .write(write), .start(start),
    .in0_real(x_re[0]), .in1_real(x_re[1]), .in2_real(x_re[2]), .in3_real(x_re[3]),
    .in4_real(x_re[4]), .in5_real(x_re[5]), .in6_real(x_re[6]), .in7_real(x_re[7]),
    .in0_imag(x_im[0]), .in1_imag(x_im[1]), .in2_imag(x_im[2]), .in3_imag(x_im[3]),
    .in4_imag(x_im[4]), .in5_imag(x_im[5]), .in6_imag(x_im[6]), .in7_imag(x_im[7]),
    .out0_real(y_re[0]), .out1_real(y_re[1]), .out2_real(y_re[2]), .out3_real(y_re[3]),
    .out4_real(y_re[4]), .out5_real(y_re[5]), .out6_real(y_re[6]), .out7_real(y_re[7]),
    .out0_imag(y_im[0]), .out1_imag(y_im[1]), .out2_imag(y_im[2]), .out3_imag(y_im[3]),
    .out4_imag(y_im[4]), .out5_imag(y_im[5]), .out6_imag(y_im[6]), .out7_imag(y_im[7]),
    .busy(busy), .ready(ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input int obs, input int exp, input int tol);
    checks++;
    if (obs > exp + tol || obs < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Negative zero on an output is never legal, so it decodes to a value no check accepts.
  function automatic int sm_to_int(input logic [15:0] v);
    int mag;
    mag = int'(v[14:0]);
    if (v == 16'h8000) return -1000000;
    return v[15] ? -mag : mag;
  endfunction

  function automatic real sm_to_real(input logic [15:0] v);
    int mag;
    mag = int'(v[14:0]);
    return v[15] ? -real'(mag) : real'(mag);
  endfunction

  function automatic int quant(input real v);
    real r;
    int  q;
`ifdef IFFT_SCALE_EN
    r = v / 8.0;
`else
    r = v;
`endif
    q = int'($floor(r + 0.5));
    if (q > 32767)  q = 32767;
    if (q < -32767) q = -32767;
    return q;
  endfunction

  task automatic push_expected(input string name, input int tol);
    real xr[8], xi[8];
    real sr, si, ang;
    for (int k = 0; k < 8; k++) begin
      xr[k] = sm_to_real(x_re[k]);
      xi[k] = sm_to_real(x_im[k]);
    end
    for (int n = 0; n < 8; n++) begin
      sr = 0.0;
      si = 0.0;
      for (int k = 0; k < 8; k++) begin
        ang = 2.0 * PI * real'(k * n) / 8.0;
        sr += xr[k] * $cos(ang) - xi[k] * $sin(ang);
        si += xr[k] * $sin(ang) + xi[k] * $cos(ang);
      end
      exp_q.push_back(quant(sr));
      exp_q.push_back(quant(si));
    end
    name_q.push_back(name);
    tol_q.push_back(tol);
  endtask

  task automatic drive(input logic w, input logic s);
    @(negedge CLK);
    write = w;
    start = s;
    @(negedge CLK);
    write = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (ready !== 1'b1 && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic compare_result();
    string nm;
    int    tol, e;
    if (name_q.size() == 0) begin
      check_val("scoreboard empty", 0, 1, 0);
      return;
    end
    nm  = name_q.pop_front();
    tol = tol_q.pop_front();
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      if (k == 0) begin
        last_exp_re0 = e;
        last_tol     = tol;
      end
      check_val($sformatf("%s out%0d_real", nm, k), sm_to_int(y_re[k]), e, tol);
      e = exp_q.pop_front();
      check_val($sformatf("%s out%0d_imag", nm, k), sm_to_int(y_im[k]), e, tol);
    end
    $display("frame %s: out0=%h+%hj out1=%h+%hj", nm, y_re[0], y_im[0], y_re[1], y_im[1]);
  endtask

  task automatic run_frame(input string name, input int tol, input logic do_write);
    int lat;
    push_expected(name, tol);
    drive(do_write, 1'b1);
    check_val({name, " busy"}, int'(busy), 1, 0);
    wait_result(lat);
    check_val({name, " latency"}, lat, 13, 0);
    compare_result();
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 8; k++) begin
      x_re[k] = 16'h0000;
      x_im[k] = 16'h0000;
    end
  endtask

  task automatic rand_frame(input int maxmag);
    int mag, sg;
    for (int k = 0; k < 8; k++) begin
      mag = $urandom_range(0, maxmag);
      sg  = $urandom_range(0, 1);
      x_re[k] = {sg[0], mag[14:0]};
      mag = $urandom_range(0, maxmag);
      sg  = $urandom_range(0, 1);
      x_im[k] = {sg[0], mag[14:0]};
    end
  endtask

  initial begin
    logic [15:0] save_re [8];
    logic [15:0] save_im [8];
    int lat;

    RST_N = 1'b0;
    write = 1'b0;
    start = 1'b0;
    clear_frame();
    #12;
    check_val("reset ready", int'(ready), 0, 0);
    check_val("reset busy", int'(busy), 0, 0);
    check_val("reset out0_real", int'(y_re[0]), 0, 0);
    check_val("reset out7_imag", int'(y_im[7]), 0, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    clear_frame();
    x_re[0] = 16'd8;
    run_frame("impulse", 0, 1'b1);

    for (int k = 0; k < 8; k++) x_re[k] = 16'd8;
    run_frame("dc", 0, 1'b1);

    clear_frame();
    x_re[1] = 16'd8192;
    run_frame("tone", 1, 1'b1);

    for (int k = 0; k < 8; k++) x_re[k] = 16'h7FFF;
    run_frame("saturate", 0, 1'b1);

    for (int f = 0; f < 3; f++) begin
      rand_frame(4000);
      run_frame($sformatf("random%0d", f), 1, 1'b1);
    end

    rand_frame(3000);
    x_re[2] = 16'h8000;
    x_im[5] = 16'h8000;
    x_re[6] = 16'h8000;
    run_frame("negzero", 1, 1'b1);

    // Result and ready must hold while idle.
    repeat (3) @(negedge CLK);
    check_val("hold ready", int'(ready), 1, 0);
    check_val("hold out0_real", sm_to_int(y_re[0]), last_exp_re0, last_tol);

    // A lone write clears ready but leaves the old result on the outputs.
    rand_frame(2000);
    drive(1'b1, 1'b0);
    check_val("write-only ready", int'(ready), 0, 0);
    check_val("write-only busy", int'(busy), 0, 0);
    check_val("write-only out0_real", sm_to_int(y_re[0]), last_exp_re0, last_tol);
    run_frame("start-only", 1, 1'b0);

    // write/start pulsed while busy must not disturb the running frame.
    rand_frame(4000);
    push_expected("busy-ignore", 1);
    drive(1'b1, 1'b1);
    repeat (3) @(negedge CLK);
    save_re = x_re;
    save_im = x_im;
    rand_frame(4000);
    write = 1'b1;
    start = 1'b1;
    @(negedge CLK);
    write = 1'b0;
    start = 1'b0;
    check_val("busy-ignore busy", int'(busy), 1, 0);
    x_re = save_re;
    x_im = save_im;
    wait_result(lat);
    check_val("busy-ignore done", int'(ready), 1, 0);
    compare_result();

    // Leave a nonzero result on the outputs, then reset in the middle of the next frame.
    clear_frame();
    x_re[1] = 16'd8192;
    run_frame("tone2", 1, 1'b1);
    rand_frame(4000);
    drive(1'b1, 1'b1);
    repeat (5) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_val("midreset busy", int'(busy), 0, 0);
    check_val("midreset ready", int'(ready), 0, 0);
    check_val("midreset out0_real", int'(y_re[0]), 0, 0);
    check_val("midreset out2_imag", int'(y_im[2]), 0, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    rand_frame(4000);
    run_frame("after-reset", 1, 1'b1);

    check_val("scoreboard drained", name_q.size(), 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
